// File: rtl/aes_key_expand128.sv
// AES-128 key expansion: generates the 11 round keys, one round per clock,
// using an external 32-bit word S-box shared through the sboxw/new_sboxw pair.
// Round keys are held in an 11x128 register memory readable by round number.
// RKEY_REG_OUT selects a combinational (0) or registered (1) round_key read port.
// Optional macro AES_KEYMEM_ZEROIZE_EN adds a zeroize input that wipes the key
// memory and aborts any expansion in progress.

module aes_key_expand128 #(
    parameter bit RKEY_REG_OUT = 1'b0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
`ifdef AES_KEYMEM_ZEROIZE_EN
    input  logic         zeroize,
`endif
    input  logic [127:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready,
    output logic [31:0]  sboxw,
    input  logic [31:0]  new_sboxw
);

    typedef enum logic {
        IDLE,
        GEN
    } state_t;

    state_t       state;
    logic [127:0] key_mem [0:10];
    logic [127:0] prev_key;
    logic [7:0]   rcon;
    logic [3:0]   round_ctr;

    logic [31:0]  t_word;
    logic [31:0]  n0;
    logic [31:0]  n1;
    logic [31:0]  n2;
    logic [31:0]  n3;
    logic [127:0] next_key;
    logic [127:0] rk_sel;

    // Multiply by x in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The S-box always sees w3 of the previous round key; in IDLE it is unused but stable.
    assign sboxw = prev_key[31:0];

    // Build the next round key from the substituted word (rotated after substitution).
    always_comb begin
        t_word   = {new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon, 24'h0};
        n0       = prev_key[127:96] ^ t_word;
        n1       = prev_key[95:64]  ^ n0;
        n2       = prev_key[63:32]  ^ n1;
        n3       = prev_key[31:0]   ^ n2;
        next_key = {n0, n1, n2, n3};
    end

    // Expansion control: accept init in IDLE, then write one round key per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 11; i++) begin
                key_mem[i] <= '0;
            end
            prev_key  <= '0;
            rcon      <= 8'h01;
            round_ctr <= 4'd0;
            ready     <= 1'b0;
            state     <= IDLE;
        end else begin
`ifdef AES_KEYMEM_ZEROIZE_EN
            if (zeroize) begin
                for (int i = 0; i < 11; i++) begin
                    key_mem[i] <= '0;
                end
                prev_key  <= '0;
                rcon      <= 8'h01;
                round_ctr <= 4'd0;
                ready     <= 1'b0;
                state     <= IDLE;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (init) begin
                            key_mem[0] <= key;
                            prev_key   <= key;
                            rcon       <= 8'h01;
                            round_ctr  <= 4'd1;
                            ready      <= 1'b0;
                            state      <= GEN;
                        end
                    end
                    GEN: begin
                        key_mem[round_ctr] <= next_key;
                        prev_key           <= next_key;
                        rcon               <= xtime(rcon);
                        round_ctr          <= round_ctr + 4'd1;
                        if (round_ctr == 4'd10) begin
                            ready <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // Round-key select; rounds beyond 10 read as zero.
    always_comb begin
        rk_sel = '0;
        if (round <= 4'd10) begin
            rk_sel = key_mem[round];
        end
    end

    generate
        if (RKEY_REG_OUT) begin : g_reg_out
            // Registered read port adds one cycle of latency from round to round_key.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    round_key <= '0;
                end else begin
                    round_key <= rk_sel;
                end
            end
        end else begin : g_comb_out
            assign round_key = rk_sel;
        end
    endgenerate

endmodule
